// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if: control/status bundle between the multicycle controller and its datapath.
interface mips_multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memready;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [2:0] alucontrol;
  logic [1:0] pcsrc;
  logic       pcen;
  logic       illegal;
  modport master (
    input  op, funct, zero, memready,
    output iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, alucontrol, pcsrc, pcen, illegal
  );
  modport slave (
    output op, funct, zero, memready,
    input  iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, alucontrol, pcsrc, pcen, illegal
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS main FSM and ALU decoder; define MIPS_BNE_EN to add bne.
module mips_multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  mips_multicycle_ctrl_if.master bus,
  output logic [STATE_W-1:0]     state_dbg
);
  localparam logic [STATE_W-1:0] FETCH   = STATE_W'(0);
  localparam logic [STATE_W-1:0] DECODE  = STATE_W'(1);
  localparam logic [STATE_W-1:0] MEMADR  = STATE_W'(2);
  localparam logic [STATE_W-1:0] MEMRD   = STATE_W'(3);
  localparam logic [STATE_W-1:0] MEMWB   = STATE_W'(4);
  localparam logic [STATE_W-1:0] MEMWR   = STATE_W'(5);
  localparam logic [STATE_W-1:0] RTYPEEX = STATE_W'(6);
  localparam logic [STATE_W-1:0] RTYPEWB = STATE_W'(7);
  localparam logic [STATE_W-1:0] BEQEX   = STATE_W'(8);
  localparam logic [STATE_W-1:0] ADDIEX  = STATE_W'(9);
  localparam logic [STATE_W-1:0] ADDIWB  = STATE_W'(10);
  localparam logic [STATE_W-1:0] JEX     = STATE_W'(11);
  localparam logic [STATE_W-1:0] BNEEX   = STATE_W'(12);
  logic [STATE_W-1:0] state, next;
  logic is_r, is_lw, is_sw, is_beq, is_addi, is_j, is_bne, legal;
  logic pcwrite, branch, branchn;
  logic [1:0] aluop;
  logic [2:0] funct_ctl;
  assign is_r    = bus.op == 6'b000000;
  assign is_lw   = bus.op == 6'b100011;
  assign is_sw   = bus.op == 6'b101011;
  assign is_beq  = bus.op == 6'b000100;
  assign is_addi = bus.op == 6'b001000;
  assign is_j    = bus.op == 6'b000010;
`ifdef MIPS_BNE_EN
  assign is_bne  = bus.op == 6'b000101;
`else
  assign is_bne  = 1'b0;
`endif
  assign legal = is_r | is_lw | is_sw | is_beq | is_addi | is_j | is_bne;
  always_ff @(posedge clk)
    if (reset) state <= FETCH;
    else state <= next;
  always_comb begin
    next = FETCH;
    case (state)
      FETCH:   next = bus.memready ? DECODE : FETCH;
      DECODE:  next = (is_lw | is_sw) ? MEMADR :
                      is_r    ? RTYPEEX :
                      is_beq  ? BEQEX :
                      is_addi ? ADDIEX :
                      is_j    ? JEX :
                      is_bne  ? BNEEX : FETCH;
      MEMADR:  next = is_lw ? MEMRD : MEMWR;
      MEMRD:   next = bus.memready ? MEMWB : MEMRD;
      MEMWR:   next = bus.memready ? FETCH : MEMWR;
      RTYPEEX: next = RTYPEWB;
      ADDIEX:  next = ADDIWB;
      default: next = FETCH;
    endcase
  end
  assign pcwrite = (state == FETCH && bus.memready) || state == JEX;
  assign branch  = state == BEQEX;
  assign branchn = state == BNEEX;
  assign aluop   = state == RTYPEEX ? 2'b10 : (branch || branchn) ? 2'b01 : 2'b00;
  // Unknown R-type functs fall back to add so the instruction still retires.
  assign funct_ctl = bus.funct == 6'b100000 ? 3'b010 :
                     bus.funct == 6'b100010 ? 3'b110 :
                     bus.funct == 6'b100100 ? 3'b000 :
                     bus.funct == 6'b100101 ? 3'b001 :
                     bus.funct == 6'b101010 ? 3'b111 : 3'b010;
  assign bus.alucontrol = aluop == 2'b10 ? funct_ctl : aluop == 2'b01 ? 3'b110 : 3'b010;
  assign bus.iord     = state == MEMRD || state == MEMWR;
  assign bus.regdst   = state == RTYPEWB;
  assign bus.memtoreg = state == MEMWB;
  assign bus.alusrca  = state == MEMADR || state == RTYPEEX || branch || branchn || state == ADDIEX;
  assign bus.alusrcb  = state == FETCH ? 2'b01 :
                        state == DECODE ? 2'b11 :
                        (state == MEMADR || state == ADDIEX) ? 2'b10 : 2'b00;
  assign bus.pcsrc    = state == JEX ? 2'b10 : (branch || branchn) ? 2'b01 : 2'b00;
  // Write strobes are gated by reset so an aborted instruction never commits.
  assign bus.memwrite = !reset && state == MEMWR;
  assign bus.irwrite  = !reset && state == FETCH && bus.memready;
  assign bus.regwrite = !reset && (state == MEMWB || state == RTYPEWB || state == ADDIWB);
  assign bus.pcen     = !reset && (pcwrite || (branch && bus.zero) || (branchn && !bus.zero));
  assign bus.illegal  = !reset && state == DECODE && !legal;
  assign state_dbg    = state;
endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Main control FSM plus ALU decoder for the multicycle MIPS datapath.
- Sequences one shared instruction/data memory, a single ALU, the instruction register and the register file over 3-5 cycles per instruction.
- Handshakes with memory via memready.
- Sits beside the multicycle datapath inside the multicycle mips top, replacing the single-cycle combinational controller.

Parameters:
- STATE_W, 4, width of the state register and of the state_dbg output.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- op  input  6  instr[31:26] from the instruction register.
- funct  input  6  instr[5:0] from the instruction register.
- zero  input  1  ALU zero flag.
- memready  input  1  memory has completed the current read/write this cycle.
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
- memwrite  output  1  memory write strobe.
- irwrite  output  1  instruction register load.
- regdst  output  1  write register select: 0 = rt, 1 = rd.
- memtoreg  output  1  writeback select: 0 = ALUOut, 1 = Data register.
- regwrite  output  1  register file write.
- alusrca  output  1  ALU A select: 0 = PC, 1 = A register.
- alusrcb  output  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- alucontrol  output  3  ALU operation.
- pcsrc  output  2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- pcen  output  1  PC register enable.
- illegal  output  1  one-cycle pulse on an unsupported opcode.
- state_dbg  output  STATE_W  current state encoding.

Behaviour:
- Opcodes:
  - R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
  - bne 000101 only with the optional feature.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11, BNEEX 12.
- Transitions:
  - FETCH -> DECODE only when memready=1, else stay in FETCH.
  - DECODE -> MEMADR for lw/sw, RTYPEEX for R-type, BEQEX for beq, ADDIEX for addi, JEX for j, BNEEX for bne.
  - DECODE -> FETCH for any other opcode, with illegal=1 for that cycle.
  - MEMADR -> MEMRD for lw, MEMWR for sw.
  - MEMRD -> MEMWB when memready=1, else hold. MEMWB -> FETCH.
  - MEMWR -> FETCH when memready=1, else hold.
  - RTYPEEX -> RTYPEWB -> FETCH. ADDIEX -> ADDIWB -> FETCH.
  - BEQEX, BNEEX, JEX -> FETCH.
- Outputs are Moore-decoded from the state. Any output not listed for a state is 0. aluop names the ALU operation: 00 add, 01 sub, 10 decode funct.
  - FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=memready, pcwrite=memready.
  - DECODE: alusrca=0, alusrcb=11, aluop=00.
  - MEMADR: alusrca=1, alusrcb=10, aluop=00.
  - MEMRD: iord=1.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1, held until and including the memready cycle.
  - RTYPEEX: alusrca=1, alusrcb=00, aluop=10.
  - RTYPEWB: regdst=1, memtoreg=0, regwrite=1.
  - BEQEX / BNEEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1 (beq) or branchn=1 (bne).
  - ADDIEX: alusrca=1, alusrcb=10, aluop=00.
  - ADDIWB: regdst=0, memtoreg=0, regwrite=1.
  - JEX: pcsrc=10, pcwrite=1.
- pcen = pcwrite | (branch & zero) | (branchn & ~zero). This is combinational on zero, within the same cycle.
- alucontrol:
  - aluop 00 -> 010 (add); aluop 01 -> 110 (sub).
  - aluop 10 decodes funct: 100000 add -> 010, 100010 sub -> 110, 100100 and -> 000, 100101 or -> 001, 101010 slt -> 111.
  - Any other funct -> 010, and the FSM still completes RTYPEWB.
- Reset:
  - While reset=1, memwrite, irwrite, regwrite, pcen and illegal are forced to 0.
  - At the clock edge where reset=1, state <= FETCH.
  - Reset asserted mid-instruction (e.g. in MEMWR) aborts the instruction; no write completes after that edge.
- memready held 0 indefinitely stalls the FSM in FETCH, MEMRD or MEMWR. During the stall, outputs are stable and pcen=0.
- Latency in cycles, with memready=1: lw 5, sw 4, R-type 4, addi 4, beq/bne/j 3.

Optional Feature:
- Macro: MIPS_BNE_EN.
- Defined: opcode 000101 goes DECODE -> BNEEX -> FETCH, and the branch is taken when zero=0.
- Undefined: state BNEEX is unreachable. Opcode 000101 is treated as illegal (DECODE -> FETCH, illegal pulse).

Test Plan:
- Reset for 2 cycles, then release with memready=1 -> state_dbg=0, all write enables 0 during reset; irwrite=1 and pcen=1 in the first FETCH cycle.
- lw (op=100011), memready=1 -> states 0,1,2,3,4; regwrite=1 with memtoreg=1 only in state 4; then back to 0.
- sw with memready low for 3 cycles in MEMWR -> memwrite=1 for 4 consecutive cycles; FETCH follows the memready cycle.
- R-type funct=101010 -> alucontrol=111 in RTYPEEX; regdst=1, regwrite=1 in RTYPEWB.
- beq with zero=1 -> pcen=1, pcsrc=01 in BEQEX.
  - With zero=0 -> pcen=0.
  - j -> pcen=1, pcsrc=10.
- op=111111 -> illegal=1 for one cycle in DECODE, then FETCH.
  - op=000101 -> illegal=1 without MIPS_BNE_EN.
  - op=000101 -> BNEEX with MIPS_BNE_EN; pcen=1 when zero=0.
  - Reset asserted in MEMWR -> memwrite=0 in that cycle, state 0 next.
